// File: rtl/nave_ctrl_pkg.sv
// Shared definitions for the player-ship controller: FSM encoding,
// default playfield coordinates used by renderer/collision blocks,
// and the button-to-direction decode.
package nave_ctrl_pkg;

  // Ship motion state: IDLE waits for a press, HOLD paces auto-repeat.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ship_st_e;

  // Default coordinates shared with the sprite and collision logic.
  localparam int NAVE_X_MIN      = 134;
  localparam int NAVE_X_MAX      = 765;
  localparam int NAVE_X_INIT     = 445;
  localparam int NAVE_SHOT_Y0    = 470;
  localparam int NAVE_SHOT_Y_MIN = 55;

  // Decoded movement request for one tick.
  typedef struct packed {
    logic mv;     // some direction is pressed
    logic right;  // move right (otherwise left)
  } dir_t;

  // Active-low buttons; right wins when both are pressed.
  function automatic dir_t decode_dir(input logic btn_l_n, input logic btn_r_n);
    dir_t d;
    d.mv    = ~btn_l_n | ~btn_r_n;
    d.right = ~btn_r_n;
    return d;
  endfunction

endpackage

// File: rtl/nave_shot.sv
// One projectile slot: holds valid/x/y and applies init > kill > spawn > move.
// Kill and init act at the next edge; motion only on frame-tick cycles.
// Kill on an idle slot is ignored, so a spawn into that slot still lands.
module nave_shot
  import nave_ctrl_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int SHOT_Y0    = NAVE_SHOT_Y0,
  parameter int SHOT_Y_MIN = NAVE_SHOT_Y_MIN,
  parameter int SHOT_SPEED = 4
) (
  input  logic           clk_i,
  input  logic           init_i,
  input  logic           tick_i,
  input  logic           kill_i,
  input  logic           spawn_i,
  input  logic [X_W-1:0] spawn_x_i,
  output logic           vld_o,
  output logic [X_W-1:0] x_o,
  output logic [X_W-1:0] y_o
);

  localparam logic [X_W-1:0] Y0_U    = X_W'(SHOT_Y0);
  localparam logic [X_W-1:0] Y_LIM_U = X_W'(SHOT_Y_MIN + SHOT_SPEED);
  localparam logic [X_W-1:0] SPD_U   = X_W'(SHOT_SPEED);

  logic           vld_q, vld_d;
  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] y_q, y_d;

  // Next-state with per-slot precedence; a shot too close to the top retires.
  always_comb begin
    vld_d = vld_q;
    x_d   = x_q;
    y_d   = y_q;
    if (init_i) begin
      vld_d = 1'b0;
      x_d   = '0;
      y_d   = '0;
    end else if (kill_i && vld_q) begin
      vld_d = 1'b0;
    end else if (spawn_i) begin
      vld_d = 1'b1;
      x_d   = spawn_x_i;
      y_d   = Y0_U;
    end else if (tick_i && vld_q) begin
      if (y_q < Y_LIM_U) vld_d = 1'b0;
      else               y_d   = y_q - SPD_U;
    end
  end

  // Slot registers; init (reset or restart) is folded into the next-state logic.
  always_ff @(posedge clk_i) begin
    vld_q <= vld_d;
    x_q   <= x_d;
    y_q   <= y_d;
  end

  assign vld_o = vld_q;
  assign x_o   = x_q;
  assign y_o   = y_q;

endmodule

// File: rtl/nave_ctrl.sv
// Player ship controller: frame-tick divider, tap/hold ship motion with clamping,
// and a pool of upward-moving shots. All outputs registered; tick-driven changes
// appear the cycle after tick=1. No backpressure: refused fires pulse fire_drop.
module nave_ctrl
  import nave_ctrl_pkg::*;
#(
  parameter int X_W          = 11,
  parameter int X_MIN        = NAVE_X_MIN,
  parameter int X_MAX        = NAVE_X_MAX,
  parameter int X_INIT       = NAVE_X_INIT,
  parameter int STEP         = 16,
  parameter int TICK_BITS    = 19,
  parameter int REPEAT_TICKS = 3,
  parameter int N_SHOTS      = 4,
  parameter int SHOT_Y0      = NAVE_SHOT_Y0,
  parameter int SHOT_Y_MIN   = NAVE_SHOT_Y_MIN,
  parameter int SHOT_SPEED   = 4,
  parameter int SHOT_X_OFS   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_A,
  input  logic                   btn_B,
  input  logic                   btn_C,
  input  logic                   btn_D,
  input  logic [N_SHOTS-1:0]     shot_kill,
  output logic [X_W-1:0]         posX,
  output logic [N_SHOTS-1:0]     shot_valid,
  output logic [N_SHOTS*X_W-1:0] shot_x,
  output logic [N_SHOTS*X_W-1:0] shot_y,
  output logic                   tick,
  output logic                   fire_drop
);

  localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [REP_W-1:0]     REP_RLD   = REP_W'(REPEAT_TICKS - 1);
  localparam logic [TICK_BITS-1:0] TICK_PRE  = {TICK_BITS{1'b1}} - 1'b1;
  localparam logic signed [X_W:0]  STEP_S    = (X_W+1)'(STEP);
  localparam logic signed [X_W:0]  X_MAX_S   = (X_W+1)'(X_MAX);
  localparam logic signed [X_W:0]  X_MIN_S   = (X_W+1)'(X_MIN);
  localparam logic [X_W-1:0]       X_MAX_U   = X_W'(X_MAX);
  localparam logic [X_W-1:0]       X_MIN_U   = X_W'(X_MIN);
  localparam logic [X_W-1:0]       X_INIT_U  = X_W'(X_INIT);
  localparam logic [X_W-1:0]       X_OFS_U   = X_W'(SHOT_X_OFS);

  logic [TICK_BITS-1:0] cnt_q, cnt_d;
  logic                 tick_q;
  ship_st_e             st_q;
  logic [REP_W-1:0]     rep_q;
  logic [X_W-1:0]       pos_q;
  logic                 fire_hist_q;
  logic                 fire_drop_q;

  logic                 init;
  dir_t                 dir;
  logic signed [X_W:0]  pos_ext, right_sum, left_diff;
  logic [X_W-1:0]       pos_right, pos_left, pos_move;
  logic [N_SHOTS-1:0]   shot_vld, free_oh, spawn_vec;
  logic                 any_free, fire_req;
  logic [X_W-1:0]       spawn_x;

  // Restart shares the init path with reset but leaves the divider running.
  assign init = reset | ~btn_D;
  assign dir  = decode_dir(btn_A, btn_B);

  // Candidate positions, computed one bit wider and signed so left never wraps.
  always_comb begin
    pos_ext   = signed'({1'b0, pos_q});
    right_sum = pos_ext + STEP_S;
    left_diff = pos_ext - STEP_S;
    pos_right = (right_sum > X_MAX_S) ? X_MAX_U : right_sum[X_W-1:0];
    pos_left  = (left_diff < X_MIN_S) ? X_MIN_U : left_diff[X_W-1:0];
    pos_move  = dir.right ? pos_right : pos_left;
  end

  // Lowest free slot as a one-hot; a slot being killed this cycle is still busy.
  always_comb begin
    free_oh   = ~shot_vld & (shot_vld + N_SHOTS'(1));
    any_free  = |free_oh;
    fire_req  = tick_q & ~btn_C & ~fire_hist_q;
    spawn_vec = fire_req ? free_oh : '0;
    spawn_x   = pos_q + X_OFS_U;
  end

  assign cnt_d = cnt_q + 1'b1;

  // Free-running divider; tick is registered so it is high while cnt is all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == TICK_PRE);
    end
  end

  // Ship FSM, fire edge detect and fire_drop, all advancing on tick cycles.
  always_ff @(posedge clk) begin
    if (init) begin
      pos_q       <= X_INIT_U;
      st_q        <= ST_IDLE;
      rep_q       <= '0;
      fire_hist_q <= 1'b0;
      fire_drop_q <= 1'b0;
    end else if (tick_q) begin
      fire_hist_q <= ~btn_C;
      fire_drop_q <= fire_req & ~any_free;
      case (st_q)
        ST_IDLE: begin
          if (dir.mv) begin
            pos_q <= pos_move;
            st_q  <= ST_HOLD;
            rep_q <= REP_RLD;
          end
        end
        ST_HOLD: begin
          if (!dir.mv) begin
            st_q <= ST_IDLE;
          end else if (rep_q != '0) begin
            rep_q <= rep_q - 1'b1;
          end else begin
            pos_q <= pos_move;
            rep_q <= REP_RLD;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end else begin
      fire_drop_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_SHOTS; g++) begin : g_shot
    nave_shot #(
      .X_W        (X_W),
      .SHOT_Y0    (SHOT_Y0),
      .SHOT_Y_MIN (SHOT_Y_MIN),
      .SHOT_SPEED (SHOT_SPEED)
    ) u_shot (
      .clk_i     (clk),
      .init_i    (init),
      .tick_i    (tick_q),
      .kill_i    (shot_kill[g]),
      .spawn_i   (spawn_vec[g]),
      .spawn_x_i (spawn_x),
      .vld_o     (shot_vld[g]),
      .x_o       (shot_x[g*X_W +: X_W]),
      .y_o       (shot_y[g*X_W +: X_W])
    );
  end

  assign posX       = pos_q;
  assign shot_valid = shot_vld;
  assign tick       = tick_q;
  assign fire_drop  = fire_drop_q;

endmodule
